// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings and constants for the MEM-stage access unit
package mem_access_unit_pkg;
    localparam int WORD = 32;
    localparam logic [WORD-1:0] PC_RST = 32'h1c000000;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSV = 2'b11} op_e;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_RSV = 2'b11} size_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;
    // Halves need bit 0 clear; words (and the reserved size, treated as word) need both low bits clear
    function automatic logic misaligned(size_e size, logic [1:0] lo);
        return (size == SZ_H) ? lo[0] : ((size != SZ_B) && (lo != 2'b00));
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/gnt/rvalid data bus between the access unit and memory
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;
    logic d_req;
    logic d_we;
    logic [WORD-1:0] d_addr;
    logic [3:0] d_wstrb;
    logic [WORD-1:0] d_wdata;
    logic d_gnt;
    logic d_rvalid;
    logic [WORD-1:0] d_rdata;
    modport master(output d_req, d_we, d_addr, d_wstrb, d_wdata, input d_gnt, d_rvalid, d_rdata);
    modport slave(input d_req, d_we, d_addr, d_wstrb, d_wdata, output d_gnt, d_rvalid, d_rdata);
endinterface

// File: rtl/mem_align.sv
// mem_align: store strobe/replication and load lane extraction with sign/zero extension
module mem_align import mem_access_unit_pkg::*; (
    input  size_e           size,
    input  logic [1:0]      lo,
    input  logic            uns,
    input  logic [WORD-1:0] wdata,
    input  logic [WORD-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [WORD-1:0] wdata_rep,
    output logic [WORD-1:0] rdata_ext
);
    logic [15:0] lane;
    // Stores replicate the low byte/half across the word; loads shift the addressed lane down and extend
    always_comb begin
        lane = 16'(rdata >> {lo, 3'b000});
        wstrb = (size == SZ_B) ? 4'b0001 << lo : (size == SZ_H) ? 4'b0011 << lo : 4'b1111;
        wdata_rep = (size == SZ_B) ? {4{wdata[7:0]}} : (size == SZ_H) ? {2{wdata[15:0]}} : wdata;
        rdata_ext = (size == SZ_B) ? {{24{~uns & lane[7]}}, lane[7:0]} :
                    (size == SZ_H) ? {{16{~uns & lane[15]}}, lane} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/gnt/rvalid bus and producing one result beat
module mem_access_unit import mem_access_unit_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] PC_RST_VAL = PC_RST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    output logic              stall,
    mem_access_unit_if.master bus,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ale
);
    state_e state, state_d;
    size_e size_q;
    logic accept, is_mem, is_store, mis, go, cap, req, pass_v, we_q, uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, wrep, rext;
    logic [3:0] strb;

    mem_align u_align (
        .size(size_q),
        .lo(addr_q[1:0]),
        .uns(uns_q),
        .wdata(wdata_q),
        .rdata(bus.d_rdata),
        .wstrb(strb),
        .wdata_rep(wrep),
        .rdata_ext(rext)
    );

    // Accept decode, next state, and the stall/bus/valid outputs
    always_comb begin
        accept = in_valid & ((state == S_IDLE) | (state == S_DONE));
        is_store = op_e'(in_op) == OP_STORE;
        is_mem = is_store | (op_e'(in_op) == OP_LOAD);
        mis = misaligned(size_e'(in_size), in_addr[1:0]);
        go = accept & is_mem & ~mis;
        cap = ~we_q & bus.d_rvalid & (((state == S_REQ) & bus.d_gnt) | (state == S_RESP));
        state_d = state;
        case (state)
            S_IDLE, S_DONE: state_d = go ? S_REQ : S_IDLE;
            S_REQ: state_d = !bus.d_gnt ? S_REQ : (we_q | bus.d_rvalid) ? S_DONE : S_RESP;
            S_RESP: state_d = bus.d_rvalid ? S_DONE : S_RESP;
            default: state_d = S_IDLE;
        endcase
        req = state == S_REQ;
        stall = go | req | (state == S_RESP);
        bus.d_req = req;
        bus.d_we = req & we_q;
        bus.d_addr = req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus.d_wstrb = (req & we_q) ? strb : 4'b0000;
        bus.d_wdata = (req & we_q) ? wrep : '0;
        out_valid = pass_v | (state == S_DONE);
    end

    // State, latched transaction, and the result registers presented to MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pass_v <= 1'b0;
            out_pc <= PC_RST_VAL;
            out_rd <= '0;
            out_wen <= 1'b0;
            out_ale <= 1'b0;
            out_result <= '0;
            we_q <= 1'b0;
            uns_q <= 1'b0;
            size_q <= SZ_B;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            pass_v <= accept & ~go;
            if (accept) begin
                out_pc <= in_pc;
                out_rd <= in_rd;
                out_wen <= in_wen & ~is_store & ~(is_mem & mis);
                out_ale <= is_mem & mis;
                out_result <= in_addr;
                we_q <= is_store;
                uns_q <= in_unsigned;
                size_q <= size_e'(in_size);
                addr_q <= in_addr;
                wdata_q <= in_wdata;
            end
            if (cap) out_result <= rext;
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register payload.
- Turns load/store ops into a req/gnt/rvalid data-bus transaction.
- Aligns and sign/zero-extends load data, builds byte strobes for stores.
- Stalls the front of the pipeline until the transaction completes, then presents one result beat to MEM/WB. Non-memory ops pass through in one cycle.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 (wstrb is 4 bits).
- PC_RST_VAL, 32'h1c000000, reset value of out_pc.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM payload valid.
- in_pc  in  32  instruction PC.
- in_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- in_unsigned  in  1  zero-extend load (ld.bu/ld.hu).
- in_addr  in  32  ALU result: effective address, or the result for non-mem ops.
- in_wdata  in  32  store data.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable from decode.
- stall  out  1  hold upstream stages; inputs must stay stable while high.
- d_req  out  1  bus request.
- d_we  out  1  write.
- d_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- d_wstrb  out  4  byte strobes.
- d_wdata  out  32  store data, replicated per size.
- d_gnt  in  1  request accepted this cycle.
- d_rvalid  in  1  read data valid.
- d_rdata  in  32  read data.
- out_valid  out  1  result beat to MEM/WB, one cycle.
- out_pc  out  32  PC.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable.
- out_result  out  32  load data or passthrough.
- out_ale  out  1  address-misalignment exception.

Behaviour:
- Reset: state IDLE. All outputs 0 except out_pc = PC_RST_VAL. rst mid-transaction abandons it with no further d_req; the bus side must tolerate a dropped response.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, in_valid, op none: register the result (out_result = in_addr, out_wen = in_wen). out_valid=1 next cycle; no stall. Back-to-back passthrough gives one result per cycle.
- IDLE, in_valid, load/store:
  - Misaligned = half with addr[0]=1, or word with addr[1:0]≠0. If misaligned: no bus transaction, next cycle out_valid=1, out_ale=1, out_wen=0; no stall.
  - Otherwise: latch address, size, data, rd, pc; go REQ. stall=1 combinationally in this cycle.
- REQ: d_req=1 with stable d_we/d_addr/d_wstrb/d_wdata until d_gnt.
  - Store + gnt -> DONE.
  - Load + gnt -> RESP.
  - Load + gnt + d_rvalid in the same cycle -> capture data, go DONE.
- RESP: wait for d_rvalid. Capture extended data -> DONE. d_rvalid seen outside REQ/RESP is ignored.
- DONE: out_valid=1 for exactly one cycle; stall=0; go IDLE.
  - Out fields: out_wen = in_wen for loads, 0 for stores; out_ale=0.
  - A new in_valid presented in DONE is accepted as if in IDLE (no bubble).
- stall = (state==IDLE & accepting an aligned mem op) | state==REQ | state==RESP.
- out_valid is 0 in every cycle not listed above.
- Store strobes:
  - byte: 4'b0001<<addr[1:0], wdata={4{b}}.
  - half: 4'b0011<<addr[1:0], wdata={2{h}}.
  - word: 4'b1111.
- Load extraction: byte lane d_rdata>>(8*addr[1:0]). Sign-extend bit 7/15 unless in_unsigned; word is passed unchanged.
- Minimum latency:
  - store: 3 cycles accept->out_valid (gnt on first REQ cycle).
  - load: 3 cycles if gnt and rvalid coincide, otherwise 4 or more.

Decomposition:
- Shared header (same one that holds PC_RST and WORD): op, size, and state encodings; PC_RST_VAL.
- One natural sub-module, mem_align: combinational strobe/replicate for stores and extract/extend for loads.

Test Plan:
- Passthrough: in_op=00, in_addr=0x12345678, rd=5, wen=1 -> next cycle out_valid=1, out_result=0x12345678, out_rd=5, stall never high.
- Store byte: addr=0x00001003, wdata=0x000000AB -> d_req, d_we=1, d_addr=0x00001000, d_wstrb=4'b1000, d_wdata=0xABABABAB; gnt held off 2 cycles -> stall high throughout, then out_valid with out_wen=0.
- Signed load half: addr=0x2002, d_rdata=0x8001_0000, rvalid 2 cycles after gnt -> out_result=0xFFFF8001. Same access with in_unsigned=1 -> out_result=0x00008001.
- Misaligned word: addr=0x2002, size=10 -> no d_req, next cycle out_valid=1, out_ale=1, out_wen=0.
- Same-cycle gnt+rvalid load word at 0x3000, rdata=0xDEADBEEF -> out_valid 3 cycles after accept, result 0xDEADBEEF. Back-to-back second op accepted in DONE.
- rst asserted while in RESP -> next cycle d_req=0, stall=0, out_valid=0, out_pc=0x1c000000. A later stray d_rvalid is ignored.
